// File: rtl/box_animator.sv
// box_animator: redraws a bouncing square box on a 160x120 VGA frame buffer, one step per accepted frame tick
module box_animator #(
  parameter int         BOX_LOG2  = 2,
  parameter logic [7:0] X_LIM     = 8'd156,
  parameter logic [6:0] Y_LIM     = 7'd116,
  parameter logic [7:0] X_INIT    = 8'd0,
  parameter logic [6:0] Y_INIT    = 7'd0,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       go,
  input  logic [2:0] fg_colour,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy
);
  localparam int PW = 2 * BOX_LOG2;
  typedef enum logic [2:0] {INIT, DRAW, WAIT, ERASE, MOVE} state_t;
  state_t        state;
  logic [7:0]    pos_x;
  logic [6:0]    pos_y;
  logic          dir_x, dir_y;
  logic [PW-1:0] pix;
  logic          nx, ny;
  // next direction: turn around at either edge so the box never leaves [0, LIM]
  always_comb begin
    nx = (dir_x && pos_x == X_LIM) ? 1'b0 : (!dir_x && pos_x == 8'd0) ? 1'b1 : dir_x;
    ny = (dir_y && pos_y == Y_LIM) ? 1'b0 : (!dir_y && pos_y == 7'd0) ? 1'b1 : dir_y;
  end
  // frame sequencer: initial draw, then per tick erase -> move -> draw -> wait
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= INIT;
      pos_x <= X_INIT;
      pos_y <= Y_INIT;
      dir_x <= 1'b1;
      dir_y <= 1'b1;
      pix   <= '0;
    end else begin
      case (state)
        INIT: state <= DRAW;
        DRAW: begin
          pix <= pix + PW'(1);
          if (&pix) state <= WAIT;
        end
        WAIT: if (frame_tick && go) state <= ERASE;
        ERASE: begin
          pix <= pix + PW'(1);
          if (&pix) state <= MOVE;
        end
        MOVE: begin
          dir_x <= nx;
          dir_y <= ny;
          pos_x <= nx ? pos_x + 8'd1 : pos_x - 8'd1;
          pos_y <= ny ? pos_y + 7'd1 : pos_y - 7'd1;
          state <= DRAW;
        end
        default: state <= INIT;
      endcase
    end
  end
  // pix is zero outside ERASE/DRAW, so the pixel address rests at the box origin
  assign plot       = (state == DRAW) || (state == ERASE);
  assign busy       = state != WAIT;
  assign x_out      = pos_x + 8'(pix[BOX_LOG2-1:0]);
  assign y_out      = pos_y + 7'(pix[PW-1:BOX_LOG2]);
  assign colour_out = (state == DRAW) ? fg_colour : (state == ERASE) ? BG_COLOUR : 3'b000;
endmodule

// File: tb/tb_box_animator.sv
// tb_box_animator: scoreboard bench for box_animator
module tb_box_animator;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0, go = 1'b0;
  logic [2:0] fg_colour = 3'b101;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;
  logic       plot, busy;
  logic       tick2 = 1'b0, go2 = 1'b0;
  logic [7:0] x2;
  logic [6:0] y2;
  logic [2:0] c2;
  logic       plot2, busy2;

  int checks = 0;
  int fails = 0;

  typedef struct {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  pix_t q[$];
  pix_t e;

  logic [7:0] mx;
  logic [6:0] my;
  logic       mdx, mdy;

  box_animator dut (
    .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .go(go), .fg_colour(fg_colour),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .plot(plot), .busy(busy)
  );

  box_animator #(.X_INIT(8'd156), .Y_INIT(7'd116)) dut2 (
    .clk(clk), .resetn(resetn), .frame_tick(tick2), .go(go2), .fg_colour(3'b011),
    .x_out(x2), .y_out(y2), .colour_out(c2), .plot(plot2), .busy(busy2)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (plot) begin
      checks++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL plot_unexpected: got (%0d,%0d) colour %0d, required no plot", x_out, y_out, colour_out);
      end else begin
        e = q.pop_front();
        if (x_out !== e.x || y_out !== e.y || colour_out !== e.c) begin
          fails++;
          $display("FAIL plot_pixel: got (%0d,%0d) colour %0d, required (%0d,%0d) colour %0d",
                   x_out, y_out, colour_out, e.x, e.y, e.c);
        end
      end
    end
  end

  task automatic push_box(input logic [2:0] c, input int n);
    for (int k = 0; k < n; k++)
      q.push_back('{mx + 8'(k % 4), my + 7'(k / 4), c});
  endtask

  task automatic model_reset();
    mx = 8'd0; my = 7'd0; mdx = 1'b1; mdy = 1'b1;
  endtask

  task automatic model_move();
    if (mdx && mx == 8'd156) mdx = 1'b0;
    else if (!mdx && mx == 8'd0) mdx = 1'b1;
    if (mdy && my == 7'd116) mdy = 1'b0;
    else if (!mdy && my == 7'd0) mdy = 1'b1;
    mx = mdx ? mx + 8'd1 : mx - 8'd1;
    my = mdy ? my + 7'd1 : my - 7'd1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, budget);
    end
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic check_rest(input string name);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || x_out !== mx || y_out !== my) begin
      fails++;
      $display("FAIL %s_rest: plot=%0d busy=%0d pos=(%0d,%0d), required 0 0 (%0d,%0d)",
               name, plot, busy, x_out, y_out, mx, my);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b1 || x_out !== 8'd0 || y_out !== 7'd0 || colour_out !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: plot=%0d busy=%0d (%0d,%0d) c=%0d, required 0 1 (0,0) 0",
               plot, busy, x_out, y_out, colour_out);
    end
    model_reset();
    push_box(fg_colour, 16);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL init_cycle: plot=%0d busy=%0d, required 0 1", plot, busy);
    end
    wait_idle("initial_draw", 40);
    check_rest("initial_draw");
  endtask

  task automatic test_frame();
    int n = 0;
    bit stop = 1'b0;
    go = 1'b1;
    push_box(3'b000, 16);
    model_move();
    push_box(fg_colour, 16);
    pulse_tick();
    for (int i = 0; i < 50 && !stop; i++) begin
      if (i > 0) @(negedge clk);
      else @(negedge clk);
      if (busy) begin
        n++;
        if (n == 17) begin
          checks++;
          if (plot !== 1'b0) begin
            fails++;
            $display("FAIL move_idle: plot=%0d in move cycle, required 0", plot);
          end
        end
      end else stop = 1'b1;
    end
    checks++;
    if (n != 33) begin
      fails++;
      $display("FAIL busy_length: busy for %0d cycles, required 33", n);
    end
    check_rest("frame");
  endtask

  task automatic test_corner();
    go2 = 1'b1;
    for (int f = 0; f < 2; f++) begin
      @(posedge clk); #1 tick2 = 1'b1;
      @(posedge clk); #1 tick2 = 1'b0;
      for (int k = 1; k <= 33; k++) begin
        @(negedge clk);
        if (k == 1) begin
          checks++;
          if (plot2 !== 1'b1 || c2 !== 3'b000 || x2 !== 8'(156 - f) || y2 !== 7'(116 - f)) begin
            fails++;
            $display("FAIL corner_erase%0d: plot=%0d (%0d,%0d) c=%0d, required 1 (%0d,%0d) 0",
                     f, plot2, x2, y2, c2, 156 - f, 116 - f);
          end
        end
        if (k == 18) begin
          checks++;
          if (plot2 !== 1'b1 || c2 !== 3'b011 || x2 !== 8'(155 - f) || y2 !== 7'(115 - f)) begin
            fails++;
            $display("FAIL corner_draw%0d: plot=%0d (%0d,%0d) c=%0d, required 1 (%0d,%0d) 3",
                     f, plot2, x2, y2, c2, 155 - f, 115 - f);
          end
        end
      end
      @(negedge clk);
      checks++;
      if (busy2 !== 1'b0) begin
        fails++;
        $display("FAIL corner_idle%0d: busy=%0d, required 0", f, busy2);
      end
    end
    go2 = 1'b0;
  endtask

  task automatic test_drop();
    int extra = 0;
    push_box(3'b000, 16);
    model_move();
    push_box(fg_colour, 16);
    pulse_tick();
    repeat (4) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    repeat (14) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    wait_idle("drop", 40);
    repeat (40) begin
      @(negedge clk);
      if (busy || plot) extra++;
    end
    checks++;
    if (extra != 0 || q.size() != 0) begin
      fails++;
      $display("FAIL drop_extra: %0d busy cycles, %0d pending plots, required 0 0", extra, q.size());
    end
    check_rest("drop");
  endtask

  task automatic test_back_to_back();
    logic [2:0] cols [5] = '{3'b001, 3'b010, 3'b100, 3'b111, 3'b110};
    for (int f = 0; f < 5; f++) begin
      push_box(3'b000, 16);
      model_move();
      fg_colour = cols[f];
      push_box(fg_colour, 16);
      pulse_tick();
      wait_idle("back_to_back", 40);
    end
    check_rest("back_to_back");
  endtask

  task automatic test_hold();
    int seen = 0;
    go = 1'b0;
    repeat (10) begin
      pulse_tick();
      repeat (3) begin
        @(negedge clk);
        if (plot || busy) seen++;
      end
    end
    checks++;
    if (seen != 0) begin
      fails++;
      $display("FAIL hold_activity: %0d active cycles with go=0, required 0", seen);
    end
    check_rest("hold");
  endtask

  task automatic test_mid_reset();
    go = 1'b1;
    push_box(3'b000, 8);
    pulse_tick();
    repeat (7) @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    @(posedge clk); #1 resetn = 1'b1;
    model_reset();
    push_box(fg_colour, 16);
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b1 || x_out !== 8'd0 || y_out !== 7'd0) begin
      fails++;
      $display("FAIL mid_reset_init: plot=%0d busy=%0d (%0d,%0d), required 0 1 (0,0)",
               plot, busy, x_out, y_out);
    end
    wait_idle("mid_reset", 40);
    check_rest("mid_reset");
  endtask

  initial begin
    test_reset();
    test_corner();
    test_frame();
    test_drop();
    test_back_to_back();
    test_hold();
    test_mid_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d plots outstanding, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
